// File: rtl/spi_frame_rx.sv
// spi_frame_rx: oversampled SPI slave receiver.
// Captures MSB-first frames, checks the bit count on chip-select release and
// queues good frames in a first-word-fall-through FIFO with valid/ready.
module spi_frame_rx #(
  parameter int C_FRAME_BITS    = 18,
  parameter int C_SAMPLE_RISE   = 1,
  parameter int C_CS_ACTIVE_LOW = 1,
  parameter int C_FIFO_DEPTH    = 4
) (
  input  logic                    OPB_Clk,
  input  logic                    rst,
  input  logic                    spi_sclk,
  input  logic                    spi_din,
  input  logic                    spi_cs,
  output logic [C_FRAME_BITS-1:0] frame_data,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    frame_len_err,
  output logic                    fifo_overflow,
  input  logic                    clr_overflow,
  output logic                    busy,
  output logic [15:0]             frame_count
);

  localparam int CW   = $clog2(C_FRAME_BITS + 2);
  localparam int AW   = $clog2(C_FIFO_DEPTH);
  localparam int FCW  = AW + 1;
  localparam logic [CW-1:0]  CNT_FULL  = CW'(C_FRAME_BITS);
  localparam logic [CW-1:0]  CNT_SAT   = CW'(C_FRAME_BITS + 1);
  localparam logic [FCW-1:0] FIFO_FULL = FCW'(C_FIFO_DEPTH);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, RECV} state_t;

  state_t state;

  logic [1:0] sclk_sync, din_sync, cs_sync;
  logic       sclk_h, din_h, cs_h;

  // Two-flop synchronisers plus one history flop per SPI pin.
  always_ff @(posedge OPB_Clk) begin
    sclk_sync <= {sclk_sync[0], spi_sclk};
    din_sync  <= {din_sync[0], spi_din};
    cs_sync   <= {cs_sync[0], spi_cs};
    sclk_h    <= sclk_sync[1];
    din_h     <= din_sync[1];
    cs_h      <= cs_sync[1];
  end

  logic cs_act, cs_act_h, cs_on, cs_off, sample_edge;

  assign cs_act      = (C_CS_ACTIVE_LOW != 0) ? ~cs_sync[1] : cs_sync[1];
  assign cs_act_h    = (C_CS_ACTIVE_LOW != 0) ? ~cs_h : cs_h;
  assign cs_on       = cs_act & ~cs_act_h;
  assign cs_off      = ~cs_act & cs_act_h;
  assign sample_edge = (C_SAMPLE_RISE != 0) ? (sclk_sync[1] & ~sclk_h)
                                            : (~sclk_sync[1] & sclk_h);

  logic [C_FRAME_BITS-1:0] shift_q, shift_nxt;
  logic [CW-1:0]           bit_cnt, bit_cnt_nxt;
  logic                    end_ok, end_bad;

  // Shift/count after the current sample edge, so an edge coincident with
  // chip-select release is counted before the length check.
  always_comb begin
    shift_nxt   = shift_q;
    bit_cnt_nxt = bit_cnt;
    if (sample_edge) begin
      shift_nxt = {shift_q[C_FRAME_BITS-2:0], din_h};
      if (bit_cnt != CNT_SAT) bit_cnt_nxt = bit_cnt + CW'(1);
    end
  end

  // Frame state machine: wait for a clean idle, receive bits, judge length.
  always_ff @(posedge OPB_Clk) begin
    if (rst) begin
      state   <= WAIT_IDLE;
      shift_q <= '0;
      bit_cnt <= '0;
      end_ok  <= 1'b0;
      end_bad <= 1'b0;
      busy    <= 1'b0;
    end else begin
      end_ok  <= 1'b0;
      end_bad <= 1'b0;
      case (state)
        WAIT_IDLE: begin
          if (!cs_act) state <= IDLE;
        end
        IDLE: begin
          if (cs_on) begin
            state   <= RECV;
            busy    <= 1'b1;
            shift_q <= '0;
            bit_cnt <= '0;
          end
        end
        RECV: begin
          shift_q <= shift_nxt;
          bit_cnt <= bit_cnt_nxt;
          if (cs_off) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (bit_cnt_nxt == CNT_FULL) end_ok  <= 1'b1;
            else                         end_bad <= 1'b1;
          end
        end
        default: begin
          state <= WAIT_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  logic [C_FRAME_BITS-1:0] mem [C_FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [FCW-1:0]          fcnt;
  logic                    pop, full, push_acc, drop;

  assign frame_valid = (fcnt != '0);
  assign frame_data  = mem[rd_ptr];
  assign pop         = frame_valid & frame_ready;
  assign full        = (fcnt == FIFO_FULL);
  assign push_acc    = end_ok & (~full | pop);
  assign drop        = end_ok & full & ~pop;

  // FIFO storage; contents need no reset since frame_valid gates them.
  always_ff @(posedge OPB_Clk) begin
    if (push_acc) mem[wr_ptr] <= shift_q;
  end

  // FIFO pointers, occupancy, counters and status flags.
  always_ff @(posedge OPB_Clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fcnt          <= '0;
      frame_len_err <= 1'b0;
      fifo_overflow <= 1'b0;
      frame_count   <= '0;
    end else begin
      frame_len_err <= end_bad;
      if (push_acc) begin
        wr_ptr      <= wr_ptr + AW'(1);
        frame_count <= frame_count + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push_acc, pop})
        2'b10:   fcnt <= fcnt + FCW'(1);
        2'b01:   fcnt <= fcnt - FCW'(1);
        default: fcnt <= fcnt;
      endcase
      if (drop)              fifo_overflow <= 1'b1;
      else if (clr_overflow) fifo_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_frame_rx.sv
// Testbench for spi_frame_rx: directed scenarios plus random frames, with a
// queue-based scoreboard checked by independent monitor processes.
module tb_spi_frame_rx;

  localparam int FB    = 18;
  localparam int DEPTH = 4;
  localparam logic [31:0] MASK = (32'h1 << FB) - 32'h1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b0;
  logic din = 1'b0;
  logic cs_a = 1'b1;
  logic cs_b = 1'b1;
  logic ready_a = 1'b0;
  logic ready_b = 1'b1;
  logic clr_a = 1'b0;
  logic clr_b = 1'b0;

  logic [FB-1:0] data_a, data_b;
  logic          valid_a, valid_b, err_a, err_b, ovf_a, ovf_b, busy_a, busy_b;
  logic [15:0]   count_a, count_b;

  always #5 clk = ~clk;

  spi_frame_rx #(.C_FRAME_BITS(FB), .C_SAMPLE_RISE(1), .C_CS_ACTIVE_LOW(1), .C_FIFO_DEPTH(DEPTH)) dut (
    .OPB_Clk(clk), .rst(rst), .spi_sclk(sclk), .spi_din(din), .spi_cs(cs_a),
    .frame_data(data_a), .frame_valid(valid_a), .frame_ready(ready_a),
    .frame_len_err(err_a), .fifo_overflow(ovf_a), .clr_overflow(clr_a),
    .busy(busy_a), .frame_count(count_a));

  spi_frame_rx #(.C_FRAME_BITS(FB), .C_SAMPLE_RISE(0), .C_CS_ACTIVE_LOW(1), .C_FIFO_DEPTH(DEPTH)) dut_f (
    .OPB_Clk(clk), .rst(rst), .spi_sclk(sclk), .spi_din(din), .spi_cs(cs_b),
    .frame_data(data_b), .frame_valid(valid_b), .frame_ready(ready_b),
    .frame_len_err(err_b), .fifo_overflow(ovf_b), .clr_overflow(clr_b),
    .busy(busy_b), .frame_count(count_b));

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_qb[$];
  int occ = 0;
  int acc_cnt = 0;
  int acc_b = 0;
  int err_exp = 0;
  logic ovf_exp = 1'b0;
  int err_pulses = 0;
  int err_cycles = 0;
  int errb_pulses = 0;
  logic err_prev = 1'b0;
  logic rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    occ     = 0;
    acc_cnt = 0;
    ovf_exp = 1'b0;
  endfunction

  // Reference model: a frame is good only with exactly FB bits; its word is
  // the bits sent, MSB first. A good frame is kept if there is room or the
  // head is popped in the very cycle it arrives.
  task automatic expect_frame(input int tgt, input logic [31:0] val, input int n, input bit pop_same);
    if (tgt == 1) begin
      if (n == FB) begin
        exp_qb.push_back(val & MASK);
        acc_b++;
      end
    end else if (n == FB) begin
      if (occ < DEPTH || pop_same) begin
        exp_q.push_back(val & MASK);
        occ++;
        acc_cnt++;
      end else begin
        ovf_exp = 1'b1;
      end
    end else begin
      err_exp++;
    end
  endtask

  // SPI master; data changes on the edge opposite the target's sample edge.
  task automatic spi_frame(input int tgt, input logic [31:0] val, input int n, input int rst_after);
    @(posedge clk); #2;
    if (tgt == 0) cs_a = 1'b0; else cs_b = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    for (int i = n - 1; i >= 0; i--) begin
      if (tgt == 0) begin
        din = val[i];
        repeat (4) @(posedge clk);
        #2 sclk = 1'b1;
        repeat (4) @(posedge clk);
        #2 sclk = 1'b0;
      end else begin
        sclk = 1'b1;
        din  = val[i];
        repeat (4) @(posedge clk);
        #2 sclk = 1'b0;
        repeat (4) @(posedge clk);
        #2;
      end
      if (n - i == rst_after) begin
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        model_reset();
      end
    end
    repeat (4) @(posedge clk);
    #2;
    if (tgt == 0) check("busy_a", 32'(busy_a), 32'(rst_after < 0));
    else          check("busy_b", 32'(busy_b), 32'(rst_after < 0));
    @(posedge clk); #2;
    if (tgt == 0) cs_a = 1'b1; else cs_b = 1'b1;
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    @(posedge clk); #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic drain_a();
    ready_a = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (!valid_a) break;
    end
    check("drain_a", 32'(valid_a), 32'd0);
    ready_a = 1'b0;
  endtask

  // Scoreboard monitor for the rising-edge instance.
  always @(negedge clk) begin
    if (!rst && valid_a && ready_a) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL pop_a: got frame 0x%0h, want none", data_a);
      end else begin
        check("pop_a", 32'(data_a), exp_q.pop_front());
        occ--;
      end
    end
  end

  // Scoreboard monitor for the falling-edge instance.
  always @(negedge clk) begin
    if (!rst && valid_b && ready_b) begin
      if (exp_qb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL pop_b: got frame 0x%0h, want none", data_b);
      end else begin
        check("pop_b", 32'(data_b), exp_qb.pop_front());
      end
    end
  end

  // Length-error pulse observer.
  always @(negedge clk) begin
    if (err_a) err_cycles++;
    if (err_a && !err_prev) err_pulses++;
    if (err_b) errb_pulses++;
    err_prev = err_a;
  end

  // Random consumer back-pressure, enabled only in the random phase.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) ready_a = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v;
    int n;
    int r;

    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_err", 32'(err_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_count", 32'(count_a), 32'd0);
    settle();

    // Good frame and its latency from chip-select release.
    spi_frame(0, 32'h2A5C3, 18, -1);
    expect_frame(0, 32'h2A5C3, 18, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    check("lat_valid_n2", 32'(valid_a), 32'd0);
    check("lat_busy_n2", 32'(busy_a), 32'd0);
    @(posedge clk); #1;
    check("lat_valid_n3", 32'(valid_a), 32'd1);
    check("first_data", 32'(data_a), 32'h2A5C3);
    check("first_count", 32'(count_a), 32'd1);
    check("first_err", 32'(err_pulses), 32'(err_exp));
    drain_a();

    // Short and long frames.
    reset_dut();
    spi_frame(0, 32'h1ABCD, 17, -1);
    expect_frame(0, 32'h1ABCD, 17, 1'b0);
    settle();
    spi_frame(0, 32'h5ABCD, 19, -1);
    expect_frame(0, 32'h5ABCD, 19, 1'b0);
    settle();
    check("len_pulses", 32'(err_pulses), 32'(err_exp));
    check("len_cycles", 32'(err_cycles), 32'(err_exp));
    check("len_valid", 32'(valid_a), 32'd0);
    check("len_count", 32'(count_a), 32'(acc_cnt));

    // Overflow with the consumer stalled.
    reset_dut();
    for (int k = 1; k <= 5; k++) begin
      spi_frame(0, 32'(k), 18, -1);
      expect_frame(0, 32'(k), 18, 1'b0);
      settle();
    end
    check("ovf_flag", 32'(ovf_a), 32'(ovf_exp));
    check("ovf_count", 32'(count_a), 32'(acc_cnt));
    check("ovf_valid", 32'(valid_a), 32'd1);
    drain_a();
    check("ovf_sticky", 32'(ovf_a), 32'd1);
    @(posedge clk); #2 clr_a = 1'b1;
    @(posedge clk); #2 clr_a = 1'b0;
    #1;
    check("ovf_clr", 32'(ovf_a), 32'd0);

    // Full FIFO with a pop in the push cycle.
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      spi_frame(0, 32'h11 + 32'(k), 18, -1);
      expect_frame(0, 32'h11 + 32'(k), 18, 1'b0);
      settle();
    end
    spi_frame(0, 32'h15, 18, -1);
    expect_frame(0, 32'h15, 18, 1'b1);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1 ready_a = 1'b1;
    @(posedge clk); #1 ready_a = 1'b0;
    settle();
    check("fullpop_ovf", 32'(ovf_a), 32'd0);
    check("fullpop_count", 32'(count_a), 32'(acc_cnt));
    drain_a();

    // Reset in the middle of a frame.
    reset_dut();
    spi_frame(0, 32'h2AAAA, 18, 9);
    settle();
    check("midrst_count", 32'(count_a), 32'd0);
    check("midrst_valid", 32'(valid_a), 32'd0);
    check("midrst_err", 32'(err_pulses), 32'(err_exp));
    spi_frame(0, 32'h3FFFF, 18, -1);
    expect_frame(0, 32'h3FFFF, 18, 1'b0);
    settle();
    check("midrst_next", 32'(count_a), 32'(acc_cnt));
    drain_a();

    // Falling-edge sampling instance.
    spi_frame(1, 32'h2A5C3, 18, -1);
    expect_frame(1, 32'h2A5C3, 18, 1'b0);
    settle();
    for (int k = 0; k < 4; k++) begin
      v = $urandom;
      spi_frame(1, v, 18, -1);
      expect_frame(1, v, 18, 1'b0);
      settle();
    end
    check("fall_count", 32'(count_b), 32'(acc_b));
    check("fall_left", 32'(exp_qb.size()), 32'd0);

    // Random frames with random back-pressure.
    rand_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      v = $urandom;
      r = int'($urandom_range(0, 9));
      if (r <= 5)      n = FB;
      else if (r == 6) n = FB - 1;
      else if (r == 7) n = FB + 1;
      else if (r == 8) n = 0;
      else             n = int'($urandom_range(1, 32));
      spi_frame(0, v, n, -1);
      expect_frame(0, v, n, 1'b0);
      settle();
    end
    rand_ready = 1'b0;
    @(posedge clk); #2;
    drain_a();

    check("end_left", 32'(exp_q.size()), 32'd0);
    check("end_pulses", 32'(err_pulses), 32'(err_exp));
    check("end_cycles", 32'(err_cycles), 32'(err_exp));
    check("end_count", 32'(count_a), 32'(acc_cnt));
    check("end_ovf", 32'(ovf_a), 32'(ovf_exp));
    check("end_ovf_b", 32'(ovf_b), 32'd0);
    check("end_err_b", 32'(errb_pulses), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_frame_rx.md
Name: spi_frame_rx

Overview:
- Oversampled SPI slave receiver on OPB_Clk; the receiving end of the radio/DAC SPI links (sclk, dout, cs).
- Captures MSB-first frames from the SPI master, checks frame length and queues complete frames in a small first-word-fall-through FIFO with valid/ready handshake.
- Used as a loopback monitor in board tests and as the front end of the simulation models for the radios and DACs.

Parameters:
- C_FRAME_BITS, 18, bits per valid frame (radio = 18, DAC = 16); range 2..32.
- C_SAMPLE_RISE, 1, 1 = sample spi_din on sclk rising edge, 0 = falling edge.
- C_CS_ACTIVE_LOW, 1, chip-select polarity.
- C_FIFO_DEPTH, 4, frame FIFO entries; power of 2, at least 2.

Ports:
- OPB_Clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- spi_sclk  in  1  SPI clock from the master; asynchronous to OPB_Clk.
- spi_din  in  1  serial data (master dout).
- spi_cs  in  1  chip select.
- frame_data  out  C_FRAME_BITS  FIFO head word; first bit received is the MSB.
- frame_valid  out  1  FIFO not empty.
- frame_ready  in  1  consumer pops the head when frame_valid && frame_ready.
- frame_len_err  out  1  one-cycle pulse: frame ended with wrong bit count.
- fifo_overflow  out  1  sticky: a complete frame was dropped because the FIFO was full.
- clr_overflow  in  1  clears fifo_overflow.
- busy  out  1  frame in progress (state RECV).
- frame_count  out  16  accepted-frame counter; wraps at 0xFFFF to 0.

Behaviour:
Input synchronisation
- spi_sclk, spi_din and spi_cs each pass through a 2-flop synchroniser plus a 1-flop history stage.
- Edges are detected from the synchronised values.
- Supported sclk: high and low phases each of at least 2 OPB_Clk periods. Faster clocks are unsupported; no detection is required.

Reset
- State goes to WAIT_IDLE.
- frame_valid=0, frame_len_err=0, fifo_overflow=0, busy=0, frame_count=0.
- FIFO is emptied; shift register and bit counter are cleared.

State machine
- WAIT_IDLE: go to IDLE once synchronised cs is inactive. Any partial frame in progress at reset is discarded silently.
- IDLE: on cs going active, go to RECV and clear the bit counter and shift register.
- RECV, on each sample edge: shift = {shift[C_FRAME_BITS-2:0], din}. The bit counter saturates at C_FRAME_BITS+1.
- RECV, on cs going inactive: return to IDLE.
  - If count == C_FRAME_BITS, push the shift register into the FIFO.
  - Otherwise pulse frame_len_err for 1 cycle and push nothing. This covers 0 bits, short frames and long frames.
- If a sample edge and cs deassert are detected in the same cycle, the edge is counted first.
- busy = 1 exactly while in RECV.

Latency
- Let edge N be the first OPB_Clk edge that samples spi_cs inactive at the pin.
- The push, or the frame_len_err pulse, is registered at edge N+3.
- frame_valid is therefore high after edge N+3 if the FIFO was empty.

FIFO
- First-word-fall-through: frame_data always shows the head entry and is valid whenever frame_valid=1.
- Pop happens when frame_valid && frame_ready.
- Push into a full FIFO: the frame is dropped and fifo_overflow is set, unless a pop occurs in the same cycle, in which case the push is accepted.
- Simultaneous push and pop on an empty FIFO: no pop occurs and the push is accepted.
- frame_count increments only on accepted pushes.
- clr_overflow clears fifo_overflow. If a drop occurs in the same cycle, set wins.
- frame_data is undefined while frame_valid=0.

Test Plan:
- Reset, then 18-bit frame 0x2A5C3 (sclk = OPB_Clk/8, sample on rise) -> frame_valid high 3 cycles after the cs-deassert sample, frame_data=0x2A5C3, frame_count=1, no frame_len_err.
- 17-bit frame, then a 19-bit frame -> two single-cycle frame_len_err pulses, FIFO stays empty, frame_count=0.
- frame_ready=0, send 5 valid frames 0x00001..0x00005 (depth 4) -> fifo_overflow=1, frame_count=4; pops return 1,2,3,4 in order; clr_overflow then clears the flag.
- FIFO full, frame_ready=1 held in the cycle the 5th frame pushes -> push accepted, no overflow, frame_count=5.
- rst pulsed after 9 bits of a frame with cs still active; finish the frame -> no push, no frame_len_err; the next full frame 0x3FFFF is received correctly.
- C_SAMPLE_RISE=0 with C_CS_ACTIVE_LOW=1, data changing on rising edges -> the frame is captured intact.
